// File: rtl/axil_wr_route_ctrl.sv
// AXI4-Lite write router: decodes AWADDR to one of NUMBER_SLAVE windows and forwards a one-deep AW/W buffer.
// Latency: accept->slave valid 1 cycle, slave B->master B 1 cycle; no new accept until master B completes.
module axil_wr_route_ctrl #(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  =
    {NUMBER_SLAVE{{{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1}}},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                           aclk,
  input  logic                                           areset,
  input  logic [AXI_ADDR_WIDTH-1:0]                      s_axil_awaddr,
  input  logic                                           s_axil_awvalid,
  output logic                                           s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                      s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]                    s_axil_wstrb,
  input  logic                                           s_axil_wvalid,
  output logic                                           s_axil_wready,
  output logic [1:0]                                     s_axil_bresp,
  output logic                                           s_axil_bvalid,
  input  logic                                           s_axil_bready,
  output logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0]    m_axil_awaddr,
  output logic [NUMBER_SLAVE-1:0]                        m_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                        m_axil_awready,
  output logic [NUMBER_SLAVE-1:0][AXI_DATA_WIDTH-1:0]    m_axil_wdata,
  output logic [NUMBER_SLAVE-1:0][AXI_DATA_WIDTH/8-1:0]  m_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]                        m_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]                        m_axil_wready,
  input  logic [NUMBER_SLAVE-1:0][1:0]                   m_axil_bresp,
  input  logic [NUMBER_SLAVE-1:0]                        m_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]                        m_axil_bready
);

  localparam int SW     = AXI_DATA_WIDTH / 8;
  localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, FWD, WAITB, RESP, DECERR} state_t;
  state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [SW-1:0]             strb_q;
  logic [NUMBER_SLAVE-1:0]   sel_q;
  logic                      aw_done, w_done;
  logic [1:0]                bresp_q;
  logic [TW-1:0]             tmo_cnt;

  logic [NUMBER_SLAVE-1:0]   hit, sel_dec;
  logic [1:0]                b_sel_resp;
  logic                      accept, aw_hs, w_hs, b_hs, tmo_hit, in_fwd_path;

  // Window end is formed one bit wider so a window reaching the top of the address space does not wrap.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      hit[i] = (AXI_ADDR_RANGE[i] != '0) &&
               ({1'b0, s_axil_awaddr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
               ({1'b0, s_axil_awaddr} <  ({1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]}));
    end
  end

  // Lowest set bit of hit: overlapping windows resolve to the lowest index.
  assign sel_dec = hit & (~hit + {{(NUMBER_SLAVE-1){1'b0}}, 1'b1});

  always_comb begin
    b_sel_resp = 2'b00;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (sel_q[i]) b_sel_resp = b_sel_resp | m_axil_bresp[i];
    end
  end

  assign in_fwd_path = (state == FWD) || (state == WAITB);
  assign tmo_hit     = TMO_EN && in_fwd_path && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  assign m_axil_awaddr = {NUMBER_SLAVE{addr_q}};
  assign m_axil_wdata  = {NUMBER_SLAVE{data_q}};
  assign m_axil_wstrb  = {NUMBER_SLAVE{strb_q}};

  always_comb begin
    state_nxt      = state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    s_axil_bresp   = 2'b00;
    m_axil_awvalid = '0;
    m_axil_wvalid  = '0;
    m_axil_bready  = '0;
    accept         = 1'b0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    b_hs           = 1'b0;
    case (state)
      IDLE: begin
        accept         = s_axil_awvalid && s_axil_wvalid && !areset;
        s_axil_awready = accept;
        s_axil_wready  = accept;
        if (accept) state_nxt = (|hit) ? FWD : DECERR;
      end
      FWD: begin
        m_axil_awvalid = aw_done ? '0 : sel_q;
        m_axil_wvalid  = w_done  ? '0 : sel_q;
        aw_hs = !tmo_hit && |(m_axil_awvalid & m_axil_awready);
        w_hs  = !tmo_hit && |(m_axil_wvalid & m_axil_wready);
        if (tmo_hit)                                        state_nxt = RESP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))    state_nxt = WAITB;
      end
      WAITB: begin
        m_axil_bready = sel_q;
        b_hs = !tmo_hit && |(sel_q & m_axil_bvalid);
        if (tmo_hit || b_hs) state_nxt = RESP;
      end
      RESP: begin
        s_axil_bvalid = 1'b1;
        s_axil_bresp  = bresp_q;
        if (s_axil_bready) state_nxt = IDLE;
      end
      DECERR: begin
        s_axil_bvalid = 1'b1;
        s_axil_bresp  = 2'b11;
        if (s_axil_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bresp_q <= 2'b00;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= s_axil_awaddr;
        data_q  <= s_axil_wdata;
        strb_q  <= s_axil_wstrb;
        sel_q   <= sel_dec;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        tmo_cnt <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (TMO_EN && in_fwd_path) tmo_cnt <= tmo_cnt + TW'(1);
      if (b_hs)    bresp_q <= b_sel_resp;
      if (tmo_hit) bresp_q <= 2'b10;
    end
  end

endmodule
